// File: rtl/s7_iserdes.sv
// s7_iserdes: single-lane LVDS receiver front end with synchronizer, tap delay, deserializer and bitslip word aligner
module s7_iserdes #(
    parameter int         DELAY_TAPS    = 4,
    parameter int         S_WIDTH       = 8,
    parameter logic [7:0] ALIGN_PATTERN = 8'hF0,
    parameter int         LOCK_COUNT    = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               rx_p,
    input  logic               rx_n,
    output logic               data_delayed,
    output logic [S_WIDTH-1:0] data_out,
    output logic               data_valid,
    output logic               locked,
    output logic [3:0]         slip_count
);
    typedef enum logic [1:0] {SEARCH, SLIP, SETTLE, LOCKED} state_t;

    localparam logic [2:0]         LAST_BIT  = 3'(S_WIDTH - 1);
    localparam logic [3:0]         LAST_SLIP = 4'(S_WIDTH - 1);
    localparam logic [3:0]         LOCK_LAST = 4'(LOCK_COUNT - 1);
    localparam logic [S_WIDTH-1:0] PAT       = ALIGN_PATTERN[S_WIDTH-1:0];

    logic                  rx_bit, s1_q;
    logic [DELAY_TAPS:0]   dl_q;
    logic [S_WIDTH-2:0]    sr_q;
    logic [S_WIDTH-1:0]    sr_d, data_q;
    logic [2:0]            bit_cnt_q;
    logic [3:0]            slip_cnt_q, match_q, match_d;
    logic                  valid_q, settle_q, settle_d, miss_q, miss_d, slip, hit;
    state_t                state_q, state_d;

    // An invalid differential pair (equal legs) keeps the previously resolved bit.
    assign rx_bit       = (rx_p != rx_n) ? rx_p : s1_q;
    assign data_delayed = dl_q[DELAY_TAPS];
    assign sr_d         = {sr_q, data_delayed};
    assign data_out     = data_q;
    assign data_valid   = valid_q;
    assign slip_count   = slip_cnt_q;
    assign slip         = state_q == SLIP;
    assign locked       = state_q == LOCKED;
    assign hit          = data_q == PAT;

    // Two-stage synchronizer feeding the delay line; dl_q[0] is the second sync stage.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1_q <= 1'b0;
            dl_q <= '0;
        end else begin
            s1_q    <= rx_bit;
            dl_q[0] <= s1_q;
            for (int i = 1; i <= DELAY_TAPS; i++) dl_q[i] <= dl_q[i-1];
        end
    end

    // Deserializer; a slip cycle freezes the bit counter so the word boundary moves one bit later.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sr_q       <= '0;
            data_q     <= '0;
            bit_cnt_q  <= '0;
            valid_q    <= 1'b0;
            slip_cnt_q <= '0;
        end else begin
            sr_q    <= sr_d[S_WIDTH-2:0];
            valid_q <= !slip && bit_cnt_q == LAST_BIT;
            if (slip) begin
                slip_cnt_q <= (slip_cnt_q == LAST_SLIP) ? 4'd0 : slip_cnt_q + 4'd1;
            end else if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q <= '0;
                data_q    <= sr_d;
            end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
        end
    end

    // Aligner state registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= SEARCH;
            match_q  <= '0;
            settle_q <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            settle_q <= settle_d;
            miss_q   <= miss_d;
        end
    end

    // Aligner next state: search for LOCK_COUNT hits, slip on a miss, drop lock after two misses in a row.
    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        settle_d = settle_q;
        miss_d   = miss_q;
        case (state_q)
            SEARCH: if (valid_q) begin
                if (hit) begin
                    match_d = match_q + 4'd1;
                    state_d = (match_q == LOCK_LAST) ? LOCKED : SEARCH;
                end else begin
                    match_d = '0;
                    state_d = SLIP;
                end
            end
            SLIP: begin
                state_d  = SETTLE;
                settle_d = 1'b0;
            end
            SETTLE: if (valid_q) begin
                settle_d = 1'b1;
                state_d  = settle_q ? SEARCH : SETTLE;
            end
            LOCKED: if (valid_q) begin
                miss_d = !hit;
                if (!hit && miss_q) begin
                    state_d = SEARCH;
                    match_d = '0;
                    miss_d  = 1'b0;
                end
            end
            default: state_d = SEARCH;
        endcase
    end
endmodule

// File: tb/tb_s7_iserdes.sv
// tb_s7_iserdes: directed checks of sync latency, leg hold, alignment, lock loss and async reset
module tb_s7_iserdes;
    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       rx_p = 1'b0;
    logic       rx_n = 1'b1;
    logic       data_delayed, data_valid, locked;
    logic [7:0] data_out;
    logic [3:0] slip_count;
    logic       dd0, dv0, lk0;
    logic [7:0] do0;
    logic [3:0] sc0;

    int checks = 0;
    int errors = 0;
    int lock_at, drops, bad_words, tail_dv;
    logic [7:0] pat = 8'hF0;
    int ph_tab[4] = '{0, 3, 5, 6};
    int sl_tab[4] = '{5, 2, 0, 7};

    always #5 sys_clk = ~sys_clk;

    s7_iserdes #(.DELAY_TAPS(4)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_p(rx_p), .rx_n(rx_n),
        .data_delayed(data_delayed), .data_out(data_out), .data_valid(data_valid),
        .locked(locked), .slip_count(slip_count)
    );

    s7_iserdes #(.DELAY_TAPS(0)) dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .rx_p(rx_p), .rx_n(rx_n),
        .data_delayed(dd0), .data_out(do0), .data_valid(dv0),
        .locked(lk0), .slip_count(sc0)
    );

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    // Drives the 1111_0000 stream; edge 1 is the first edge after reset release; f1/f2 flip one bit each.
    task automatic run_stream(input int ph, input int ncyc, input int f1, input int f2);
        lock_at = 0; drops = 0; bad_words = 0; tail_dv = 0;
        for (int j = 1; j <= ncyc; j++) begin
            rx_p = pat[7 - ((j + ph) % 8)] ^ (j == f1 || j == f2);
            rx_n = ~rx_p;
            @(posedge sys_clk);
            @(negedge sys_clk);
            if (data_valid && j > ncyc - 16) tail_dv++;
            if (locked) begin
                if (lock_at == 0) lock_at = j;
                if (data_valid && data_out !== 8'hF0) bad_words++;
            end else if (lock_at != 0) begin
                drops++;
            end
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge sys_clk);
            rx_p = ~rx_p;
            rx_n = ~rx_p;
        end
        checks += 6;
        if (data_delayed !== 1'b0) begin errors++; $display("FAIL reset_dd act=%0b exp=0", data_delayed); end
        if (dd0 !== 1'b0) begin errors++; $display("FAIL reset_dd0 act=%0b exp=0", dd0); end
        if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid act=%0b exp=0", data_valid); end
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked act=%0b exp=0", locked); end
        if (slip_count !== 4'd0) begin errors++; $display("FAIL reset_slip act=%0d exp=0", slip_count); end
        if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data act=%h exp=00", data_out); end
    endtask

    task automatic edge_latency(input string tag);
        for (int i = 0; i < 7; i++) begin
            @(posedge sys_clk);
            #1;
            checks += 2;
            if (data_delayed !== (i >= 5)) begin errors++; $display("FAIL %s_t4 edge+%0d act=%0b exp=%0b", tag, i, data_delayed, i >= 5); end
            if (dd0 !== (i >= 1)) begin errors++; $display("FAIL %s_t0 edge+%0d act=%0b exp=%0b", tag, i, dd0, i >= 1); end
        end
    endtask

    task automatic test_latency();
        do_reset();
        rx_p = 1'b0; rx_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        rx_p = 1'b1; rx_n = 1'b0;
        edge_latency("latency");
    endtask

    task automatic test_hold();
        @(negedge sys_clk);
        rx_p = 1'b0; rx_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        rx_p = 1'b1; rx_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        checks += 2;
        if (data_delayed !== 1'b0) begin errors++; $display("FAIL hold_t4 act=%0b exp=0", data_delayed); end
        if (dd0 !== 1'b0) begin errors++; $display("FAIL hold_t0 act=%0b exp=0", dd0); end
        rx_n = 1'b0;
        edge_latency("restore");
    endtask

    task automatic check_lock(input string tag, input int exp_slip);
        checks += 5;
        if (lock_at == 0 || lock_at > 448) begin errors++; $display("FAIL %s_lock_time act=%0d exp=1..448", tag, lock_at); end
        if (locked !== 1'b1) begin errors++; $display("FAIL %s_locked act=%0b exp=1", tag, locked); end
        if (slip_count !== 4'(exp_slip)) begin errors++; $display("FAIL %s_slip act=%0d exp=%0d", tag, slip_count, exp_slip); end
        if (data_out !== 8'hF0) begin errors++; $display("FAIL %s_word act=%h exp=f0", tag, data_out); end
        if (tail_dv != 2) begin errors++; $display("FAIL %s_strobes act=%0d exp=2", tag, tail_dv); end
    endtask

    task automatic test_align();
        for (int k = 0; k < 4; k++) begin
            do_reset();
            run_stream(ph_tab[k], 700, 0, 0);
            check_lock($sformatf("align_ph%0d", ph_tab[k]), sl_tab[k]);
            checks += 2;
            if (drops != 0) begin errors++; $display("FAIL align_ph%0d_drops act=%0d exp=0", ph_tab[k], drops); end
            if (bad_words != 0) begin errors++; $display("FAIL align_ph%0d_badwords act=%0d exp=0", ph_tab[k], bad_words); end
        end
    endtask

    task automatic test_corrupt();
        do_reset();
        run_stream(3, 700, 500, 0);
        check_lock("single_miss", 2);
        checks += 2;
        if (drops != 0) begin errors++; $display("FAIL single_miss_drops act=%0d exp=0", drops); end
        if (bad_words != 1) begin errors++; $display("FAIL single_miss_badwords act=%0d exp=1", bad_words); end
        do_reset();
        run_stream(3, 700, 500, 508);
        checks += 3;
        if (drops == 0) begin errors++; $display("FAIL double_miss_drop act=%0d exp=>0", drops); end
        if (locked !== 1'b1) begin errors++; $display("FAIL double_miss_relock act=%0b exp=1", locked); end
        if (slip_count !== 4'd2) begin errors++; $display("FAIL double_miss_slip act=%0d exp=2", slip_count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        run_stream(6, 400, 0, 0);
        checks += 1;
        if (locked !== 1'b1) begin errors++; $display("FAIL async_prelock act=%0b exp=1", locked); end
        @(posedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        checks += 5;
        if (data_delayed !== 1'b0) begin errors++; $display("FAIL async_dd act=%0b exp=0", data_delayed); end
        if (data_out !== 8'h00) begin errors++; $display("FAIL async_data act=%h exp=00", data_out); end
        if (data_valid !== 1'b0) begin errors++; $display("FAIL async_valid act=%0b exp=0", data_valid); end
        if (locked !== 1'b0) begin errors++; $display("FAIL async_locked act=%0b exp=0", locked); end
        if (slip_count !== 4'd0) begin errors++; $display("FAIL async_slip act=%0d exp=0", slip_count); end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        run_stream(6, 700, 0, 0);
        check_lock("async_relock", 7);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_hold();
        test_align();
        test_corrupt();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
